// File: rtl/dma_priority_controller.sv
// Four-channel DMA priority controller: arbitrates masked requests (fixed or
// rotating), runs the bus handshake and strobe sequence, and tracks terminal counts.
module dma_priority_controller #(
  parameter int unsigned NCH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           DREQ,
  input  logic [NCH-1:0]           mask,
  input  logic                     rotate,
  input  logic [NCH-1:0]           burst,
  input  logic [NCH-1:0]           dir,
  input  logic                     HLDA,
  input  logic                     tc_in,
  input  logic                     status_clr,
  output logic                     HRQ,
  output logic                     AEN,
  output logic [NCH-1:0]           DACK,
  output logic [$clog2(NCH)-1:0]   ch_select,
  output logic                     IOR,
  output logic                     IOW,
  output logic                     MEMR,
  output logic                     MEMW,
  output logic                     IOflag,
  output logic [NCH-1:0]           tc_status
);

  localparam int unsigned CW = $clog2(NCH);

  typedef enum logic [2:0] {IDLE, REQ, S1, S2, S3, S4} state_t;

  state_t          state;
  logic [CW-1:0]   ch;
  logic [CW-1:0]   ptr;
  logic            holdoff;
  logic            tc_seen;

  logic [NCH-1:0]  elig_c;
  logic [CW-1:0]   base_c;
  logic [CW-1:0]   idx_c;
  logic [CW-1:0]   win_c;
  logic [3:0]      strb_c;
  logic            cont_c;

  // Priority search from the current highest-priority channel; lowest offset wins.
  always_comb begin
    elig_c = DREQ & ~mask;
    base_c = rotate ? ptr : '0;
    idx_c  = '0;
    win_c  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx_c = CW'(base_c + CW'(i));
      if (elig_c[idx_c]) win_c = idx_c;
    end
  end

  // Active strobe pattern as {IOR, IOW, MEMR, MEMW}.
  always_comb begin
    strb_c = dir[ch] ? 4'b0110 : 4'b1001;
    cont_c = burst[ch] && !tc_seen && DREQ[ch] && !mask[ch];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ch        <= '0;
      ptr       <= '0;
      holdoff   <= 1'b0;
      tc_seen   <= 1'b0;
      HRQ       <= 1'b0;
      AEN       <= 1'b0;
      DACK      <= '0;
      ch_select <= '0;
      {IOR, IOW, MEMR, MEMW} <= 4'b1111;
      IOflag    <= 1'b0;
      tc_status <= '0;
    end else begin
      IOflag <= 1'b0;
      // A terminal-count set later in this block overrides the clear for its bit.
      if (status_clr) tc_status <= '0;
      case (state)
        IDLE: begin
          if (holdoff) begin
            holdoff <= 1'b0;
          end else if (|elig_c) begin
            state <= REQ;
            HRQ   <= 1'b1;
            ch    <= win_c;
          end
        end
        REQ: begin
          if (HLDA) begin
            state     <= S1;
            AEN       <= 1'b1;
            DACK      <= NCH'(1) << ch;
            ch_select <= ch;
          end
        end
        S1, S2, S3, S4: begin
          if (!HLDA) begin
            state   <= IDLE;
            HRQ     <= 1'b0;
            AEN     <= 1'b0;
            DACK    <= '0;
            holdoff <= 1'b1;
            {IOR, IOW, MEMR, MEMW} <= 4'b1111;
          end else begin
            case (state)
              S1: begin
                state <= S2;
                {IOR, IOW, MEMR, MEMW} <= strb_c;
              end
              S2: begin
                state  <= S3;
                IOflag <= 1'b1;
              end
              S3: begin
                state   <= S4;
                tc_seen <= tc_in;
                {IOR, IOW, MEMR, MEMW} <= 4'b1111;
                if (tc_in) tc_status[ch] <= 1'b1;
              end
              default: begin
                ptr <= CW'(ch + CW'(1));
                if (cont_c) begin
                  state <= S2;
                  {IOR, IOW, MEMR, MEMW} <= strb_c;
                end else begin
                  state   <= IDLE;
                  HRQ     <= 1'b0;
                  AEN     <= 1'b0;
                  DACK    <= '0;
                  holdoff <= 1'b1;
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_controller.sv
// Scenario bench for dma_priority_controller: grant scoreboard plus cycle-level checks.
module tb_dma_priority_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] DREQ, mask, burst, dir;
  logic       rotate, HLDA, tc_in, status_clr;
  logic       HRQ, AEN, IOR, IOW, MEMR, MEMW, IOflag;
  logic [3:0] DACK, tc_status;
  logic [1:0] ch_select;
  logic [3:0] strb;

  int checks = 0;
  int errors = 0;
  int ioflag_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] grant_q[$];
  logic aen_d = 1'b0;

  always #5 clk = ~clk;
  assign strb = {IOR, IOW, MEMR, MEMW};

  dma_priority_controller #(.NCH(4)) dut (
    .clk(clk), .reset(reset), .DREQ(DREQ), .mask(mask), .rotate(rotate),
    .burst(burst), .dir(dir), .HLDA(HLDA), .tc_in(tc_in), .status_clr(status_clr),
    .HRQ(HRQ), .AEN(AEN), .DACK(DACK), .ch_select(ch_select),
    .IOR(IOR), .IOW(IOW), .MEMR(MEMR), .MEMW(MEMW), .IOflag(IOflag),
    .tc_status(tc_status)
  );

  // Grant monitor: records DACK on each entry into S1 and counts IOflag pulses.
  always @(posedge clk) begin
    #1;
    if (AEN && !aen_d) grant_q.push_back(DACK);
    if (IOflag) ioflag_cnt++;
    aen_d = AEN;
  end

  task automatic do_reset();
    reset = 1'b1; DREQ = '0; mask = '0; rotate = 1'b0; burst = '0; dir = '0;
    HLDA = 1'b0; tc_in = 1'b0; status_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); grant_q.delete(); ioflag_cnt = 0;
  endtask

  task automatic wait_grants(input int n, output bit ok);
    for (int i = 0; i < 80 && grant_q.size() < n; i++) @(negedge clk);
    ok = (grant_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 80 && (HRQ || AEN); i++) @(negedge clk);
    ok = !HRQ && !AEN;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (HRQ !== 1'b0 || AEN !== 1'b0) begin errors++; $display("FAIL reset_hrq_aen got %b%b exp 00", HRQ, AEN); end
    checks++; if (DACK !== 4'b0000) begin errors++; $display("FAIL reset_dack got %b exp 0000", DACK); end
    checks++; if (ch_select !== 2'd0) begin errors++; $display("FAIL reset_ch_select got %0d exp 0", ch_select); end
    checks++; if (strb !== 4'b1111) begin errors++; $display("FAIL reset_strobes got %b exp 1111", strb); end
    checks++; if (IOflag !== 1'b0 || tc_status !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b/%b exp 0/0000", IOflag, tc_status); end
  endtask

  task automatic test_fixed();
    bit ok;
    logic [3:0] e, g;
    do_reset();
    rotate = 1'b0; HLDA = 1'b1; DREQ = 4'b1010;
    exp_q.push_back(4'b0010);
    wait_grants(1, ok);
    DREQ = '0;
    checks++; if (!ok) begin errors++; $display("FAIL fixed_timeout got %0d grants exp 1", grant_q.size()); end
    checks++; if (ch_select !== 2'd1) begin errors++; $display("FAIL fixed_ch_select got %0d exp 1", ch_select); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (grant_q.size() > 0) ? grant_q.pop_front() : 4'bxxxx;
      checks++; if (g !== e) begin errors++; $display("FAIL fixed_grant got %b exp %b", g, e); end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL fixed_idle got HRQ=%b exp 0", HRQ); end
  endtask

  task automatic test_rotate();
    bit ok;
    logic [3:0] e, g;
    do_reset();
    rotate = 1'b1; HLDA = 1'b1; DREQ = 4'b0011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    wait_grants(2, ok);
    DREQ = '0;
    checks++; if (!ok) begin errors++; $display("FAIL rotate_timeout got %0d grants exp 2", grant_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (grant_q.size() > 0) ? grant_q.pop_front() : 4'bxxxx;
      checks++; if (g !== e) begin errors++; $display("FAIL rotate_grant got %b exp %b", g, e); end
    end
    wait_idle(ok);
  endtask

  task automatic test_single();
    logic [3:0] e, g;
    do_reset();
    dir = 4'b0100; DREQ = 4'b0100;
    exp_q.push_back(4'b0100);
    repeat (3) @(negedge clk);
    checks++; if (HRQ !== 1'b1 || AEN !== 1'b0) begin errors++; $display("FAIL single_req got HRQ/AEN %b%b exp 10", HRQ, AEN); end
    HLDA = 1'b1;
    @(negedge clk);
    checks++; if (AEN !== 1'b1 || DACK !== 4'b0100 || ch_select !== 2'd2) begin errors++; $display("FAIL single_s1 got %b %b %0d exp 1 0100 2", AEN, DACK, ch_select); end
    DREQ = '0;
    @(negedge clk);
    checks++; if (strb !== 4'b0110 || IOflag !== 1'b0) begin errors++; $display("FAIL single_s2 got %b/%b exp 0110/0", strb, IOflag); end
    @(negedge clk);
    checks++; if (strb !== 4'b0110 || IOflag !== 1'b1) begin errors++; $display("FAIL single_s3 got %b/%b exp 0110/1", strb, IOflag); end
    @(negedge clk);
    checks++; if (strb !== 4'b1111 || IOflag !== 1'b0 || HRQ !== 1'b1) begin errors++; $display("FAIL single_s4 got %b/%b/%b exp 1111/0/1", strb, IOflag, HRQ); end
    @(negedge clk);
    checks++; if (HRQ !== 1'b0 || AEN !== 1'b0 || DACK !== 4'b0000) begin errors++; $display("FAIL single_idle got %b %b %b exp 0 0 0000", HRQ, AEN, DACK); end
    checks++; if (ioflag_cnt != 1) begin errors++; $display("FAIL single_ioflag_count got %0d exp 1", ioflag_cnt); end
    e = exp_q.pop_front();
    g = (grant_q.size() > 0) ? grant_q.pop_front() : 4'bxxxx;
    checks++; if (g !== e) begin errors++; $display("FAIL single_grant got %b exp %b", g, e); end
  endtask

  task automatic test_block();
    int n;
    logic [3:0] e, g;
    do_reset();
    burst = 4'b0001; dir = 4'b0000; DREQ = 4'b0001; HLDA = 1'b1;
    exp_q.push_back(4'b0001);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      tc_in = 1'b0;
      if (IOflag) begin
        n++;
        if (n == 1) begin
          checks++; if (strb !== 4'b1001) begin errors++; $display("FAIL block_strobes got %b exp 1001", strb); end
        end
        tc_in = (n == 3);
      end
      if (n > 0 && !HRQ) break;
    end
    DREQ = '0;
    checks++; if (n != 3 || ioflag_cnt != 3) begin errors++; $display("FAIL block_ioflags got %0d/%0d exp 3", n, ioflag_cnt); end
    checks++; if (tc_status !== 4'b0001) begin errors++; $display("FAIL block_tc_status got %b exp 0001", tc_status); end
    checks++; if (HRQ !== 1'b0 || AEN !== 1'b0) begin errors++; $display("FAIL block_idle got %b%b exp 00", HRQ, AEN); end
    e = exp_q.pop_front();
    g = (grant_q.size() > 0) ? grant_q.pop_front() : 4'bxxxx;
    checks++; if (g !== e || grant_q.size() != 0) begin errors++; $display("FAIL block_grant got %b (+%0d) exp %b", g, grant_q.size(), e); end
  endtask

  task automatic test_hlda_drop();
    logic [3:0] e, g;
    repeat (3) @(negedge clk);
    ioflag_cnt = 0;
    dir = 4'b0100; burst = 4'b0100; DREQ = 4'b0100; HLDA = 1'b1;
    exp_q.push_back(4'b0100);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (IOR === 1'b0) break;
    end
    HLDA = 1'b0; tc_in = 1'b1;
    @(negedge clk);
    checks++; if (HRQ !== 1'b0 || AEN !== 1'b0 || DACK !== 4'b0000) begin errors++; $display("FAIL drop_idle got %b %b %b exp 0 0 0000", HRQ, AEN, DACK); end
    checks++; if (strb !== 4'b1111 || IOflag !== 1'b0) begin errors++; $display("FAIL drop_strobes got %b/%b exp 1111/0", strb, IOflag); end
    checks++; if (tc_status !== 4'b0001 || ioflag_cnt != 0) begin errors++; $display("FAIL drop_status got %b/%0d exp 0001/0", tc_status, ioflag_cnt); end
    DREQ = '0; tc_in = 1'b0; HLDA = 1'b1; burst = '0;
    e = exp_q.pop_front();
    g = (grant_q.size() > 0) ? grant_q.pop_front() : 4'bxxxx;
    checks++; if (g !== e) begin errors++; $display("FAIL drop_grant got %b exp %b", g, e); end
  endtask

  task automatic test_tc_clear();
    bit ok;
    logic [3:0] e, g;
    repeat (3) @(negedge clk);
    DREQ = 4'b0010; HLDA = 1'b1;
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (IOflag) break;
    end
    tc_in = 1'b1; status_clr = 1'b1; DREQ = '0;
    @(negedge clk);
    checks++; if (tc_status !== 4'b0010) begin errors++; $display("FAIL tc_set_wins got %b exp 0010", tc_status); end
    tc_in = 1'b0; status_clr = 1'b0;
    wait_idle(ok);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    checks++; if (tc_status !== 4'b0000) begin errors++; $display("FAIL tc_clear got %b exp 0000", tc_status); end
    e = exp_q.pop_front();
    g = (grant_q.size() > 0) ? grant_q.pop_front() : 4'bxxxx;
    checks++; if (g !== e) begin errors++; $display("FAIL tc_grant got %b exp %b", g, e); end
  endtask

  task automatic test_reset_mid();
    bit hrq_seen;
    repeat (3) @(negedge clk);
    DREQ = 4'b0001; burst = '0; HLDA = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (IOflag) break;
    end
    reset = 1'b1; tc_in = 1'b1;
    @(negedge clk);
    checks++; if (HRQ !== 1'b0 || AEN !== 1'b0 || DACK !== 4'b0000 || ch_select !== 2'd0) begin errors++; $display("FAIL midreset_ctrl got %b %b %b %0d exp 0 0 0000 0", HRQ, AEN, DACK, ch_select); end
    checks++; if (strb !== 4'b1111 || IOflag !== 1'b0 || tc_status !== 4'b0000) begin errors++; $display("FAIL midreset_out got %b/%b/%b exp 1111/0/0000", strb, IOflag, tc_status); end
    reset = 1'b0; tc_in = 1'b0;
    grant_q.delete();
    DREQ = 4'b1111; mask = 4'b1111;
    hrq_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      hrq_seen |= HRQ;
    end
    checks++; if (hrq_seen !== 1'b0 || grant_q.size() != 0) begin errors++; $display("FAIL masked_hrq got %b (%0d grants) exp 0", hrq_seen, grant_q.size()); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rotate();
    test_single();
    test_block();
    test_hlda_drop();
    test_tc_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_priority_controller.md
DMA_PRIORITY_CONTROLLER -- requirements
Module: dma_priority_controller

Interface
REQ-001 Parameter: NCH, default 4, number of DMA channels; only 4 is supported.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: DREQ  input  4  per-channel DMA request, active-high, level-sensitive.
REQ-005 Port: mask  input  4  per-channel mask; 1 means the channel is ignored.
REQ-006 Port: rotate  input  1  0 selects fixed priority, 1 selects rotating priority.
REQ-007 Port: burst  input  4  per-channel mode; 1 is block transfer, 0 is single transfer.
REQ-008 Port: dir  input  4  per-channel direction; 1 is I/O to memory, 0 is memory to I/O.
REQ-009 Port: HLDA  input  1  bus grant from the CPU, active-high.
REQ-010 Port: tc_in  input  1  word count of the active channel is exhausted, from the address/count block.
REQ-011 Port: status_clr  input  1  one-cycle pulse that clears tc_status.
REQ-012 Port: HRQ  output  1  bus request to the CPU.
REQ-013 Port: AEN  output  1  DMA owns the address bus.
REQ-014 Port: DACK  output  4  one-hot acknowledge to the serviced channel.
REQ-015 Port: ch_select  output  2  index of the serviced channel.
REQ-016 Port: IOR, IOW, MEMR, MEMW  output  1 each  active-low bus strobes.
REQ-017 Port: IOflag  output  1  one-cycle pulse commanding the address/count block to step.
REQ-018 Port: tc_status  output  4  sticky per-channel terminal-count flags.

Function
REQ-019 The controller SHALL implement a state machine with states IDLE, REQ, S1, S2, S3, S4.
REQ-020 The eligible request vector SHALL be DREQ & ~mask, sampled only in IDLE.
REQ-021 IDLE SHALL go to REQ when any channel is eligible; HRQ SHALL assert in the cycle REQ is entered and remain high through S4.
REQ-022 The winning channel SHALL be latched on the IDLE-to-REQ transition and SHALL stay stable until the controller returns to IDLE.
REQ-023 Under fixed priority, channel 0 SHALL be highest and channel 3 lowest.
REQ-024 Under rotating priority, the channel serviced last SHALL become lowest priority and the next channel upward (modulo 4) highest; the rotation pointer SHALL update on leaving S4.
REQ-025 REQ SHALL wait indefinitely for HLDA=1, then go to S1.
REQ-026 S1 SHALL assert AEN, DACK[ch] and ch_select; these SHALL stay asserted through S4.
REQ-027 Strobes in S2 and S3 when dir=1: IOR=0 and MEMW=0.
REQ-028 Strobes in S2 and S3 when dir=0: MEMR=0 and IOW=0.
REQ-029 All strobes SHALL be high in every other state.
REQ-030 IOflag SHALL pulse high for exactly the S3 cycle, once per transfer.
REQ-031 tc_in SHALL be sampled in S3.
REQ-032 If tc_in=1 in S3, tc_status[ch] SHALL set in S4.
REQ-033 S4 SHALL go to S2 (next transfer, HRQ, AEN and DACK held) only when burst[ch]=1, tc_in was 0, DREQ[ch]=1 and mask[ch]=0.
REQ-034 In all other S4 cases, the controller SHALL go to IDLE and deassert HRQ, AEN and DACK in that same IDLE cycle.
REQ-035 A single transfer SHALL occupy 4 cycles, S1 through S4; subsequent block transfers SHALL occupy 3 cycles each.
REQ-036 If HLDA drops in S1-S4, the controller SHALL enter IDLE next cycle with all strobes high and no IOflag.
REQ-037 DREQ changes while not in IDLE or S4 SHALL be ignored.
REQ-038 If status_clr and a TC set occur in the same cycle, the set SHALL win for that bit; all other bits SHALL clear.
REQ-039 IDLE SHALL NOT re-arbitrate until one full cycle with HRQ=0 has elapsed.

Reset
REQ-040 Reset SHALL take effect at the next edge from any state, including mid-transfer.
REQ-041 Reset values: state IDLE, HRQ=0, AEN=0, DACK=0, ch_select=0, IOR=IOW=MEMR=MEMW=1, IOflag=0, tc_status=0, rotation pointer giving channel 0 highest priority.

Verification
REQ-042 Fixed priority: rotate=0, DREQ=4'b1010, HLDA held high -> ch1 serviced first, DACK=4'b0010, ch_select=1.
REQ-043 Rotating priority: rotate=1, DREQ=4'b0011 held for two services -> ch0 serviced, then ch1 (DACK=0001 then 0010).
REQ-044 Single transfer: dir=1 on ch2 -> REQ to S1 one cycle after HLDA; IOR=MEMW=0 for 2 cycles; one IOflag; HRQ=0 after S4.
REQ-045 Block transfer: burst[0]=1, DREQ[0] held, tc_in=1 on the third S3 -> 3 IOflag pulses, tc_status=4'b0001, then IDLE.
REQ-046 HLDA dropped in S2 -> next cycle IDLE, all strobes high, no IOflag, tc_status unchanged.
REQ-047 Reset asserted in S3 -> next cycle all outputs at reset values; masked DREQ=4'b1111 with mask=4'b1111 -> HRQ stays 0.
